riscv_dbus_master: RTL and testbench
====================================

# riscv_dbus_master

Memory-stage data-bus master: turns the M-stage load/store into a request/grant/response transaction on the data bus. It drives `i_bus_stallM` of the hazard unit (`o_bus_stallM` here), holding the pipeline until the bus completes. It also formats byte/half/word accesses and reports access faults and bus timeouts. It sits between the EM pipeline register and the data-memory/peripheral bus.

## Interface
- `BUS_TIMEOUT`, default 255: cycles spent in ADDR+DATA before the access is aborted. Legal range 2..65535.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_mem_req`  in  1  M-stage instruction is a load/store; held stable while `o_bus_stallM`=1.
- `i_mem_we`  in  1  1 = store, 0 = load.
- `i_mem_funct3`  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `i_mem_addr`  in  32  byte address.
- `i_mem_wdata`  in  32  store data (rs2).
- `o_bus_stallM`  out  1  to hazard unit; 1 = freeze F..EM.
- `o_load_data`  out  32  sign/zero-extended load result; valid only in the completion cycle.
- `o_mem_exc`  out  1  misaligned or illegal funct3; no bus access made.
- `o_bus_err`  out  1  one-cycle pulse: access aborted by timeout.
- `o_bus_req`  out  1  request valid.
- `o_bus_we`  out  1  write strobe.
- `o_bus_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `o_bus_be`  out  4  byte enables.
- `o_bus_wdata`  out  32  lane-replicated write data.
- `i_bus_gnt`  in  1  request accepted this cycle.
- `i_bus_rvalid`  in  1  response (read data or write ack), exactly one per grant, at least 1 cycle after grant.
- `i_bus_rdata`  in  32  read data, valid with `i_bus_rvalid`.

## Operation
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR: on `i_mem_req` & ~fault. Request fields (we, be, word addr, wdata, funct3, addr[1:0]) are registered at this edge.
  - ADDR: `o_bus_req`=1; request fields held stable until `i_bus_gnt`. ADDR -> DATA on `i_bus_gnt`.
  - DATA: `o_bus_req`=0. DATA -> IDLE on `i_bus_rvalid`.
- Fault: W with addr[1:0]≠0, H/HU with addr[0]=1, or funct3 ∈ {011,110,111}. Handling:
  - `o_mem_exc`=`i_mem_req`&fault, combinational; FSM stays IDLE.
  - Stall is 0 and no bus request is made.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction: select lane by registered addr[1:0].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
  - `o_load_data`=0 outside a completion cycle.
- Stall: `o_bus_stallM` = `i_mem_req` & ~fault & ~complete.
  - complete = (DATA & `i_bus_rvalid`) | timeout.
  - Stall is therefore 1 in the IDLE cycle where the request first appears.
- Timeout counter:
  - Cleared on IDLE->ADDR; increments each cycle in ADDR or DATA.
  - When count = BUS_TIMEOUT-1 without completion: timeout=1 for that cycle, `o_bus_err`=1, `o_load_data`=0, stall drops, next state IDLE.
- `i_bus_rvalid`/`i_bus_gnt` while in IDLE are ignored (late response after timeout or reset).
- Same-edge completion and new request: the pipeline advances on the completion edge. A new `i_mem_req` seen in the following IDLE cycle starts a fresh access; the FSM never re-issues the completed one.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, counter 0. Outputs `o_bus_req`=0, `o_bus_we`=0, `o_bus_be`=0, `o_bus_addr`=0, `o_bus_wdata`=0, `o_bus_err`=0, `o_mem_exc`=0, `o_bus_stallM`=0, `o_load_data`=0. Reset mid-transaction abandons it.
- Minimum access cycle sequence:
  - c0: IDLE, stall=1.
  - c1: ADDR, req=1, gnt=1.
  - c2: DATA, rvalid=1, stall=0, data valid.
  - Result: 2 stall cycles.
- Each cycle without `i_bus_gnt` (ADDR) or `i_bus_rvalid` (DATA) adds one stall cycle.
- `o_load_data`, `o_bus_err`, and stall release are combinational in the completion cycle; the MB register captures the result at the end of that cycle.

## Test plan
- LW addr 0x100, gnt in c1, rvalid in c2 with rdata 0xDEADBEEF -> stall 1 in c0–c1, 0 in c2; `o_load_data`=0xDEADBEEF; `o_bus_be`=4'b1111.
- LB addr 0x103, rdata 0x80_00_00_00 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102, rdata 0xBEEF_0000 -> 0x0000BEEF.
- SB addr 0x201, wdata 0x123456AB -> `o_bus_addr`=0x200, be=4'b0010, wdata=0xABABABAB, `o_bus_we`=1; gnt held off 3 cycles -> fields stable throughout, stall lasts 5 cycles.
- LW addr 0x102 -> `o_mem_exc`=1, stall=0, `o_bus_req` never asserted. funct3=011 -> same response.
- BUS_TIMEOUT=8, gnt at c1, no rvalid -> `o_bus_err` pulse at count 7, stall drops, data 0. A late rvalid in IDLE is ignored and the next LW completes normally.
- `rst_n`=0 while in DATA -> next cycle all outputs at reset values; a subsequent rvalid is ignored.

Source files
------------

// File: rtl/riscv_dbus_master.sv
// riscv_dbus_master
// Memory-stage data-bus master. Converts the M-stage load/store into a
// request/grant/response bus transaction, stalls the pipeline until the
// access completes, formats byte/half/word lanes and reports misaligned
// or illegal accesses and bus timeouts.

module riscv_dbus_master #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // M-stage side
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [2:0]  i_mem_funct3,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_bus_stallM,
    output logic [31:0] o_load_data,
    output logic        o_mem_exc,
    output logic        o_bus_err,
    // Data bus side
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Last counter value before the access is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(BUS_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    // Request fields captured when the access is issued.
    logic        we_q;
    logic [3:0]  be_q;
    logic [29:0] waddr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        fault;
    logic        misaligned;
    logic        illegal_f3;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        issue;
    logic        in_bus;
    logic        rsp;
    logic        timeout;
    logic        complete;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Decode alignment and funct3 legality of the incoming access.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        misaligned = 1'b0;
        illegal_f3 = 1'b0;
        case (i_mem_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = i_mem_addr[0];
            3'b010:         misaligned = |i_mem_addr[1:0];
            default:        illegal_f3 = 1'b1;
        endcase
    end

    assign fault = misaligned | illegal_f3;

    // Build byte enables and lane-replicated write data for the new access.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_mem_wdata;
        case (i_mem_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << i_mem_addr[1:0];
                wdata_new = {4{i_mem_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {i_mem_addr[1], 1'b0};
                wdata_new = {2{i_mem_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = i_mem_wdata;
            end
        endcase
    end

    assign issue    = (state_q == S_IDLE) & i_mem_req & ~fault;
    assign in_bus   = (state_q == S_ADDR) | (state_q == S_DATA);
    assign rsp      = (state_q == S_DATA) & i_bus_rvalid;
    assign timeout  = in_bus & (cnt_q == CNT_LAST) & ~rsp;
    assign complete = rsp | timeout;

    // Next-state and timeout-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_ADDR;
                    cnt_d   = 16'd0;
                end
            end
            S_ADDR: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (i_bus_gnt) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (complete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and request-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            waddr_q  <= 30'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                we_q     <= i_mem_we;
                be_q     <= be_new;
                waddr_q  <= i_mem_addr[31:2];
                wdata_q  <= wdata_new;
                funct3_q <= i_mem_funct3;
                off_q    <= i_mem_addr[1:0];
            end
        end
    end

    // Shift the addressed lane down and extend it according to the load type.
    always_comb begin
        lane = i_bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    assign o_load_data  = rsp ? load_ext : 32'd0;
    assign o_bus_stallM = i_mem_req & ~fault & ~complete;
    assign o_mem_exc    = i_mem_req & fault;
    assign o_bus_err    = timeout;

    assign o_bus_req    = (state_q == S_ADDR);
    assign o_bus_we     = we_q;
    assign o_bus_addr   = {waddr_q, 2'b00};
    assign o_bus_be     = be_q;
    assign o_bus_wdata  = wdata_q;

endmodule

// File: tb/tb_riscv_dbus_master.sv
// tb_riscv_dbus_master
// Directed bench for riscv_dbus_master with a transaction-level reference
// model checked every cycle, plus literal expectations per scenario.

module tb_riscv_dbus_master;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mem_req;
    logic        i_mem_we;
    logic [2:0]  i_mem_funct3;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic        o_bus_stallM;
    logic [31:0] o_load_data;
    logic        o_mem_exc;
    logic        o_bus_err;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    int tests = 0;
    int fails = 0;

    riscv_dbus_master #(.BUS_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mem_req    (i_mem_req),
        .i_mem_we     (i_mem_we),
        .i_mem_funct3 (i_mem_funct3),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .o_bus_stallM (o_bus_stallM),
        .o_load_data  (o_load_data),
        .o_mem_exc    (o_mem_exc),
        .o_bus_err    (o_bus_err),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_be     (o_bus_be),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int msize(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit mfault(input logic [2:0] f3, input logic [31:0] a);
        int s;
        s = msize(f3);
        if (s == 0) return 1'b1;
        return (int'(a[1:0]) % s) != 0;
    endfunction

    function automatic logic [3:0] mbe(input logic [2:0] f3, input logic [31:0] a);
        int b;
        b = ((1 << msize(f3)) - 1) << int'(a[1:0]);
        return 4'(b);
    endfunction

    function automatic logic [31:0] mwdata(input logic [2:0] f3, input logic [31:0] w);
        case (msize(f3))
            1:       return {24'd0, w[7:0]} * 32'h0101_0101;
            2:       return {16'd0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * int'(off));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Model state: one outstanding access, whether it was granted, its age.
    bit          m_act = 1'b0;
    bit          m_gr  = 1'b0;
    int          m_age = 0;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wd;

    // Per-cycle comparison against the model, then advance the model.
    initial begin
        bit flt, rsp, to, comp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            flt  = mfault(i_mem_funct3, i_mem_addr);
            rsp  = m_act && m_gr && i_bus_rvalid;
            to   = m_act && (m_age == int'(T) - 1) && !rsp;
            comp = rsp || to;
            check("m.stall", o_bus_stallM, i_mem_req && !flt && !comp);
            check("m.exc",   o_mem_exc,    i_mem_req && flt);
            check("m.err",   o_bus_err,    to);
            check("m.req",   o_bus_req,    m_act && !m_gr);
            if (m_act && !m_gr) begin
                check("m.we",    o_bus_we,    m_we);
                check("m.be",    o_bus_be,    mbe(m_f3, m_addr));
                check("m.addr",  o_bus_addr,  {m_addr[31:2], 2'b00});
                check("m.wdata", o_bus_wdata, mwdata(m_f3, m_wd));
            end
            if (!(rsp && m_we))
                check("m.load", o_load_data, rsp ? mload(m_f3, m_addr[1:0], i_bus_rdata) : 32'd0);
            if (!rst_n) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (i_mem_req && !flt) begin
                    m_act = 1'b1; m_gr = 1'b0; m_age = 0;
                    m_we = i_mem_we; m_f3 = i_mem_funct3; m_addr = i_mem_addr; m_wd = i_mem_wdata;
                end
            end else if (comp) begin
                m_act = 1'b0;
            end else begin
                if (!m_gr && i_bus_gnt) m_gr = 1'b1;
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_funct3 = 3'd0;
        i_mem_addr = 32'd0; i_mem_wdata = 32'd0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},   o_bus_req,    1'b0);
        check({tag, ".we"},    o_bus_we,     1'b0);
        check({tag, ".be"},    o_bus_be,     4'd0);
        check({tag, ".addr"},  o_bus_addr,   32'd0);
        check({tag, ".wdata"}, o_bus_wdata,  32'd0);
        check({tag, ".err"},   o_bus_err,    1'b0);
        check({tag, ".exc"},   o_mem_exc,    1'b0);
        check({tag, ".stall"}, o_bus_stallM, 1'b0);
        check({tag, ".load"},  o_load_data,  32'd0);
    endtask

    // One access with gd cycles of grant delay and rd cycles of response delay.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rd, input logic [31:0] rdata,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] eload);
        int stalls;
        stalls = 0;
        i_mem_req = 1'b1; i_mem_we = we; i_mem_funct3 = f3;
        i_mem_addr = addr; i_mem_wdata = wd;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
        @(negedge clk);
        if (o_bus_stallM) stalls++;
        step();
        for (int i = 0; i <= gd; i++) begin
            i_bus_gnt = (i == gd);
            @(negedge clk);
            if (o_bus_stallM) stalls++;
            check({tag, ".be"},    o_bus_be,    ebe);
            check({tag, ".addr"},  o_bus_addr,  {addr[31:2], 2'b00});
            check({tag, ".wdata"}, o_bus_wdata, ewd);
            check({tag, ".we"},    o_bus_we,    we);
            step();
        end
        i_bus_gnt = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            i_bus_rvalid = (i == rd);
            i_bus_rdata  = (i == rd) ? rdata : 32'h0;
            @(negedge clk);
            if (o_bus_stallM) stalls++;
            if (i == rd && !we) check({tag, ".load"}, o_load_data, eload);
            step();
        end
        i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
        check({tag, ".stalls"}, stalls, 2 + gd + rd);
    endtask

    task automatic fault_probe(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_funct3 = f3; i_mem_addr = addr;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, ".exc"},   o_mem_exc,    1'b1);
            check({tag, ".stall"}, o_bus_stallM, 1'b0);
            check({tag, ".req"},   o_bus_req,    1'b0);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("rst");
        step();
        rst_n = 1'b1;
        step();

        // Loads, back to back
        access("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
        access("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8000_0000, 4'b1000, 32'h0, 32'hFFFFFF80);
        access("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8000_0000, 4'b1000, 32'h0, 32'h00000080);
        access("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'hBEEF_0000, 4'b1100, 32'h0, 32'h0000BEEF);
        idle_inputs();
        step();

        // Stores and delayed handshakes
        access("sb201", 1'b1, 3'b000, 32'h201, 32'h123456AB, 3, 0, 32'h0, 4'b0010, 32'hABABABAB, 32'h0);
        access("sh102", 1'b1, 3'b001, 32'h102, 32'h0000CAFE, 1, 2, 32'h0, 4'b1100, 32'hCAFECAFE, 32'h0);
        access("lh100", 1'b0, 3'b001, 32'h100, 32'h0, 0, 1, 32'h0000_8001, 4'b0011, 32'h0, 32'hFFFF8001);
        access("sw10c", 1'b1, 3'b010, 32'h10C, 32'h11223344, 2, 1, 32'h0, 4'b1111, 32'h11223344, 32'h0);
        idle_inputs();
        step();

        // Faulting accesses
        fault_probe("lw102",  3'b010, 32'h102);
        fault_probe("f3_011", 3'b011, 32'h100);
        fault_probe("lh101",  3'b001, 32'h101);
        fault_probe("lhu103", 3'b101, 32'h103);
        fault_probe("f3_110", 3'b110, 32'h100);
        step();

        // Timeout in DATA, then late response ignored, then normal load
        i_mem_req = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h300;
        step();
        i_bus_gnt = 1'b1;
        step();
        i_bus_gnt = 1'b0;
        for (int i = 0; i < int'(T) - 1; i++) begin
            @(negedge clk);
            check("to.err", o_bus_err, (i == int'(T) - 2));
            if (i == int'(T) - 2) begin
                check("to.stall", o_bus_stallM, 1'b0);
                check("to.load",  o_load_data,  32'd0);
            end
            step();
        end
        idle_inputs();
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("late.load", o_load_data, 32'd0);
        check("late.req",  o_bus_req,   1'b0);
        step();
        idle_inputs();
        access("lw104", 1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 32'h55AA55AA, 4'b1111, 32'h0, 32'h55AA55AA);

        // Timeout with the grant never arriving, then a late grant in IDLE
        i_mem_funct3 = 3'b100; i_mem_addr = 32'h400;
        step();
        for (int i = 0; i < int'(T); i++) begin
            @(negedge clk);
            check("toa.req", o_bus_req, 1'b1);
            check("toa.err", o_bus_err, (i == int'(T) - 1));
            step();
        end
        idle_inputs();
        i_bus_gnt = 1'b1;
        step();
        i_bus_gnt = 1'b0;
        @(negedge clk);
        check("lategnt.req", o_bus_req, 1'b0);
        step();

        // Reset while in DATA
        i_mem_req = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h500;
        step();
        i_bus_gnt = 1'b1;
        step();
        i_bus_gnt = 1'b0;
        rst_n = 1'b0;
        i_mem_req = 1'b0;
        step();
        rst_n = 1'b1;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h12345678;
        @(negedge clk);
        check_reset_outputs("midrst");
        step();
        idle_inputs();
        step();
        access("lw600", 1'b0, 3'b010, 32'h600, 32'h0, 1, 1, 32'hA5A5_0F0F, 4'b1111, 32'h0, 32'hA5A50F0F);
        idle_inputs();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a wedged run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
